// File: rtl/phase_seq_ctrl.sv
// Dwell sequencer for the 8-phase Johnson-counter phase generator: strobes the
// counter EN so each phase lasts its programmed dwell + 1 cycles.
module phase_seq_ctrl #(
  parameter int NPH = 8,
  parameter int DW  = 4,
  parameter int LW  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                stop,
  input  logic                abort,
  input  logic                mode,
  input  logic [NPH*DW-1:0]   dwell,
  output logic                cnt_en,
  output logic [NPH-1:0]      phase,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LW-1:0]       loops,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NPH-1:0] PH0 = NPH'(1);

  state_t              r_state;
  logic [NPH-1:0]      r_phase;
  logic [DW-1:0]       r_dcnt;
  logic [NPH*DW-1:0]   r_shadow_dwell;
  logic                r_shadow_mode;
  logic                r_stop_pend;
  logic                r_aborted;
  logic [LW-1:0]       r_loops;

  state_t              w_state_nx;
  logic [NPH-1:0]      w_phase_nx;
  logic [DW-1:0]       w_dcnt_nx;
  logic [NPH*DW-1:0]   w_shadow_dwell_nx;
  logic                w_shadow_mode_nx;
  logic                w_stop_pend_nx;
  logic                w_aborted_nx;
  logic [LW-1:0]       w_loops_nx;
  logic                w_cnt_en;
  logic [DW-1:0]       w_next_dwell;

  // Shadow dwell of the phase we are about to advance into.
  always_comb begin
    w_next_dwell = r_shadow_dwell[DW-1:0];
    for (int p = 0; p < NPH - 1; p++) begin
      if (r_phase[p]) w_next_dwell = r_shadow_dwell[(p+1)*DW +: DW];
    end
  end

  always_comb begin
    w_state_nx        = r_state;
    w_phase_nx        = r_phase;
    w_dcnt_nx         = r_dcnt;
    w_shadow_dwell_nx = r_shadow_dwell;
    w_shadow_mode_nx  = r_shadow_mode;
    w_stop_pend_nx    = r_stop_pend;
    w_aborted_nx      = r_aborted;
    w_loops_nx        = r_loops;
    w_cnt_en          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx        = S_RUN;
          w_shadow_dwell_nx = dwell;
          w_shadow_mode_nx  = mode;
          w_phase_nx        = PH0;
          w_dcnt_nx         = dwell[DW-1:0];
          w_loops_nx        = '0;
          w_aborted_nx      = 1'b0;
          w_stop_pend_nx    = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort beats stop and suppresses the advance strobe and loop count.
          w_state_nx   = S_DONE;
          w_phase_nx   = '0;
          w_dcnt_nx    = '0;
          w_aborted_nx = 1'b1;
        end else begin
          if (stop) w_stop_pend_nx = 1'b1;
          if (r_dcnt == '0) begin
            w_cnt_en = 1'b1;
            if (r_phase[NPH-1]) begin
              w_loops_nx = r_loops + LW'(1);
              // A stop arriving in the sweep's final cycle still ends this sweep.
              if (r_shadow_mode && !(r_stop_pend || stop)) begin
                w_phase_nx = PH0;
                w_dcnt_nx  = r_shadow_dwell[DW-1:0];
              end else begin
                w_state_nx = S_DONE;
                w_phase_nx = '0;
                w_dcnt_nx  = '0;
              end
            end else begin
              w_phase_nx = {r_phase[NPH-2:0], r_phase[NPH-1]};
              w_dcnt_nx  = w_next_dwell;
            end
          end else begin
            w_dcnt_nx = r_dcnt - DW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_dcnt         <= '0;
      r_shadow_dwell <= '0;
      r_shadow_mode  <= 1'b0;
      r_stop_pend    <= 1'b0;
      r_aborted      <= 1'b0;
      r_loops        <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_phase        <= w_phase_nx;
      r_dcnt         <= w_dcnt_nx;
      r_shadow_dwell <= w_shadow_dwell_nx;
      r_shadow_mode  <= w_shadow_mode_nx;
      r_stop_pend    <= w_stop_pend_nx;
      r_aborted      <= w_aborted_nx;
      r_loops        <= w_loops_nx;
    end
  end

  assign cnt_en    = w_cnt_en;
  assign phase     = r_phase;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign aborted   = r_aborted;
  assign loops     = r_loops;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed bench for phase_seq_ctrl: expected per-cycle output records are
// queued when stimulus is driven and compared each cycle at the falling edge.
module tb_phase_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, stop, abort, mode;
  logic [31:0] dwell;
  logic        cnt_en, busy, done, aborted;
  logic [7:0]  phase, loops;
  logic [1:0]  dbg_state;

  // Record layout: {state, busy, done, cnt_en, phase, loops, aborted}
  logic [21:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  string       tag    = "reset";

  phase_seq_ctrl #(.NPH(8), .DW(4), .LW(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .abort(abort),
    .mode(mode), .dwell(dwell), .cnt_en(cnt_en), .phase(phase),
    .busy(busy), .done(done), .aborted(aborted), .loops(loops),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [21:0] rec(input logic b, input logic d, input logic ce,
                                      input logic [7:0] ph, input logic [7:0] lp,
                                      input logic ab);
    logic [1:0] st;
    st = b ? 2'd1 : (d ? 2'd2 : 2'd0);
    return {st, b, d, ce, ph, lp, ab};
  endfunction

  task automatic push_idle(input logic [7:0] lp, input logic ab, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 8'h00, lp, ab));
  endtask

  task automatic push_done(input logic [7:0] lp, input logic ab);
    exp_q.push_back(rec(1'b0, 1'b1, 1'b0, 8'h00, lp, ab));
  endtask

  // One sweep: phase p holds dwell[p]+1 cycles, strobe on its last cycle.
  // cut >= 0 keeps only the first cut records; cut_abort clears the strobe of the last kept one.
  task automatic push_sweep(input logic [31:0] dw, input logic [7:0] lp,
                            input int cut, input logic cut_abort);
    int n;
    int d;
    logic ce;
    n = 0;
    for (int p = 0; p < 8; p++) begin
      d = int'(dw[p*4 +: 4]);
      for (int c = 0; c <= d; c++) begin
        if (cut >= 0 && n >= cut) return;
        ce = (c == d) && !(cut_abort && n == cut - 1);
        exp_q.push_back(rec(1'b1, 1'b0, ce, 8'(1 << p), lp, 1'b0));
        n++;
      end
    end
  endtask

  task automatic check_now();
    logic [21:0] exp_v;
    logic [21:0] obs_v;
    obs_v = {dbg_state, busy, done, cnt_en, phase, loops, aborted};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s cyc=%0d: expected queue empty, observed %h", tag, cyc, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic run_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_now();
      cyc++;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; mode = 1'b0; dwell = '0;
    @(posedge CLK); #1;
    push_idle(8'd0, 1'b0, 1);
    run_checks(1);
    RST = 1'b1;
    push_idle(8'd0, 1'b0, 2);
    run_checks(2);

    // One-shot, all-zero dwell: strobe every cycle, phase 01..80.
    tag = "oneshot_d0";
    start = 1'b1; mode = 1'b0; dwell = 32'h0000_0000;
    push_idle(8'd0, 1'b0, 1);
    run_checks(1);
    start = 1'b0;
    push_sweep(32'h0000_0000, 8'd0, -1, 1'b0);
    push_done(8'd1, 1'b0);
    push_idle(8'd1, 1'b0, 2);
    run_checks(11);

    // One-shot, phase 0 dwell 3, others 1: 18-cycle sweep.
    tag = "oneshot_mixed";
    start = 1'b1; dwell = 32'h1111_1113;
    push_idle(8'd1, 1'b0, 1);
    run_checks(1);
    start = 1'b0;
    push_sweep(32'h1111_1113, 8'd0, -1, 1'b0);
    push_done(8'd1, 1'b0);
    push_idle(8'd1, 1'b0, 2);
    run_checks(21);

    // Continuous, stop pulsed in phase 3 of the third sweep.
    tag = "cont_stop";
    start = 1'b1; mode = 1'b1; dwell = 32'h0000_0000;
    push_idle(8'd1, 1'b0, 1);
    run_checks(1);
    start = 1'b0;
    for (int s = 0; s < 3; s++) push_sweep(32'h0000_0000, 8'(s), -1, 1'b0);
    push_done(8'd3, 1'b0);
    push_idle(8'd3, 1'b0, 2);
    run_checks(19);
    stop = 1'b1;
    run_checks(1);
    stop = 1'b0;
    run_checks(7);

    // Continuous, abort on the strobe cycle of phase 5 in the second sweep.
    tag = "cont_abort";
    start = 1'b1; mode = 1'b1; dwell = 32'h2010_3021;
    push_idle(8'd3, 1'b0, 1);
    run_checks(1);
    start = 1'b0;
    push_sweep(32'h2010_3021, 8'd0, -1, 1'b0);
    push_sweep(32'h2010_3021, 8'd1, 13, 1'b1);
    push_done(8'd1, 1'b1);
    push_idle(8'd1, 1'b1, 2);
    run_checks(29);
    abort = 1'b1;
    run_checks(1);
    abort = 1'b0;
    run_checks(3);

    // start+abort in IDLE starts cleanly; later start/dwell/mode changes are ignored.
    tag = "start_abort_shadow";
    start = 1'b1; abort = 1'b1; mode = 1'b0; dwell = 32'h0000_0100;
    push_idle(8'd1, 1'b1, 1);
    run_checks(1);
    abort = 1'b0; dwell = 32'hFFFF_FFFF; mode = 1'b1;
    push_sweep(32'h0000_0100, 8'd0, -1, 1'b0);
    push_done(8'd1, 1'b0);
    push_idle(8'd1, 1'b0, 2);
    run_checks(5);
    start = 1'b0;
    run_checks(7);

    // Asynchronous reset in the middle of phase 4 of a continuous run.
    tag = "async_reset";
    start = 1'b1; mode = 1'b1; dwell = 32'h1111_1111;
    push_idle(8'd1, 1'b0, 1);
    run_checks(1);
    start = 1'b0;
    push_sweep(32'h1111_1111, 8'd0, 9, 1'b0);
    run_checks(9);
    #2;
    RST = 1'b0;
    #1;
    push_idle(8'd0, 1'b0, 1);
    check_now();
    @(posedge CLK); #1;
    RST = 1'b1;
    push_idle(8'd0, 1'b0, 3);
    run_checks(3);

    tag = "queue_drained";
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d leftover entries, expected 0", tag, exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_seq_ctrl.md
Name: phase_seq_ctrl

Overview:
- Sequencer for the 8-phase Johnson-counter clock/phase generator.
- Generates the counter's EN strobe so each phase dwells a programmable number of cycles.
- Mirrors the one-hot phase internally; supports one-shot and continuous sweeps, graceful stop, immediate abort.
- Sits between the flow-control logic and the phase counter; counter CLK is the same clock.

Parameters:
- NPH, 8, number of phases; fixed to the Johnson counter length.
- DW, 4, per-phase dwell field width.
- LW, 8, loop-counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled in IDLE only.
- stop  in  1  request graceful stop at end of current sweep.
- abort  in  1  immediate termination.
- mode  in  1  0 = one-shot (single sweep), 1 = continuous.
- dwell  in  NPH*DW  per-phase dwell; phase p uses bits [p*DW +: DW].
- cnt_en  out  1  advance strobe to the phase counter EN.
- phase  out  NPH  one-hot current phase (bit 0 = phase 0).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on leaving RUN.
- aborted  out  1  last run ended by abort; held until next start.
- loops  out  LW  completed full sweeps since last start.

Behaviour:
- Reset (RST low, async): state IDLE; phase = 0; cnt_en = 0; busy = 0; done = 0; aborted = 0; loops = 0; dwell counter = 0; stop_pend = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge moves to RUN.
  - Same edge: latch dwell and mode into shadow registers, set phase = 0000_0001 and dcnt = dwell[0].
  - Same edge: loops = 0, aborted = 0, stop_pend = 0.
  - stop and abort are ignored in IDLE.
- RUN:
  - busy = 1.
  - Each cycle with dcnt != 0: dcnt decrements.
  - When dcnt == 0: cnt_en = 1 (combinational, same cycle), so the counter and phase advance on the same edge.
  - On advance: phase rotates left by 1; dcnt loads the shadow dwell of the new phase.
  - Phase p therefore lasts shadow_dwell[p] + 1 cycles; dwell 0 gives 1 cycle.
  - Full sweep = sum(dwell[p] + 1).
- End of sweep: advance out of phase 7 (dcnt == 0 and phase[7]).
  - loops increments, wrapping mod 2^LW.
  - If mode = 1 and stop_pend = 0: phase wraps to bit 0 and dwell reloads; remain in RUN.
  - Otherwise: go to DONE, phase = 0, cnt_en still pulses on that edge.
- stop in RUN sets stop_pend; the sweep completes normally, then DONE.
- abort in RUN:
  - Next edge goes to DONE; phase = 0; aborted = 1.
  - cnt_en forced 0 that cycle.
  - loops not incremented, even if abort coincides with the end-of-sweep advance.
- DONE: done = 1 for exactly one cycle, busy = 0; next state IDLE. start in DONE is ignored.
- Simultaneous events:
  - abort + stop: abort wins.
  - start while busy: ignored.
- Shadow registers: dwell/mode changes during RUN take effect only at the next start.
- cnt_en is 0 outside RUN.
- Reset mid-run aborts asynchronously to reset values; done is not pulsed.

Test Plan:
- Reset, then start with mode = 0, dwell = all 0 -> cnt_en high 8 consecutive cycles; phase walks 01, 02 … 80; done pulses 1 cycle later; loops = 1; busy low.
- mode = 0, dwell[0] = 3, others 1 -> phase 0 holds 4 cycles, each other phase 2 cycles; sweep 18 cycles; cnt_en asserted only on last cycle of each phase.
- mode = 1, dwell = all 0, run 20 cycles, then pulse stop in phase 3 -> loops reaches 3 at end of that sweep; exit to DONE; phase = 0.
- mode = 1, abort in phase 5 of sweep 2 -> next cycle phase = 0, done pulse, aborted = 1, loops = 1. A new start clears aborted and loops.
- start + abort same cycle in IDLE -> run starts, aborted = 0. During RUN, change dwell to all F and assert start -> no timing change, no restart.
- RST low mid-phase 4 -> all outputs 0 immediately (asynchronous); after release, the controller stays in IDLE until start.
